// File: rtl/score_text_ctrl_if.sv
// +----------------------------------------------------------------------+
// | score_text_ctrl_if                                                   |
// | Point-award, VGA scan-position and glyph-ROM signals of the score    |
// | text block, with master/slave views.                                 |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface score_text_ctrl_if;
  logic       add_valid;
  logic [7:0] add_points;
  logic       score_clear;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic [9:0] rom_addr;
  logic [7:0] rom_data;
  logic       score_pixel;
  logic       busy;

  modport master (
    output add_valid, add_points, score_clear, DrawX, DrawY, rom_data,
    input  rom_addr, score_pixel, busy
  );

  modport slave (
    input  add_valid, add_points, score_clear, DrawX, DrawY, rom_data,
    output rom_addr, score_pixel, busy
  );
endinterface

`default_nettype wire

// File: rtl/score_text_ctrl.sv
// +----------------------------------------------------------------------+
// | score_text_ctrl                                                      |
// | Saturating score, sequential double-dabble BCD conversion and a      |
// | 2-stage glyph-ROM pixel pipeline drawing "SCORE: nnnnn".             |
// | Optional: define SCORE_BLANK_LZ_EN to blank leading zero digits.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module score_text_ctrl #(
  parameter logic [9:0] X0        = 10'd8,
  parameter logic [9:0] Y0        = 10'd8,
  parameter int         DIGITS    = 5,
  parameter int         SCORE_W   = 17,
  parameter int         SCORE_MAX = 99999
) (
  input  logic             Clk,
  input  logic             Reset,
  score_text_ctrl_if.slave bus
);

  localparam int               BCD_W   = 4 * DIGITS;
  localparam int               SHIFT_W = BCD_W + SCORE_W;
  localparam int               CHARS   = 7 + DIGITS;
  localparam int               CNT_W   = $clog2(SCORE_W + 1);
  localparam logic [SCORE_W:0] SAT     = (SCORE_W + 1)'(SCORE_MAX);
  localparam logic [10:0]      X_END   = 11'(X0) + 11'(8 * CHARS);
  localparam logic [10:0]      Y_END   = 11'(Y0) + 11'd16;
  localparam logic [4:0]       G_SPACE = 5'd6;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_COMMIT  = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [SCORE_W-1:0]       score_q, score_d;
  logic [SCORE_W:0]         sum_w;
  logic                     pending_q, pending_d;
  logic [SHIFT_W-1:0]       shift_q, shift_d, adj_w;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [DIGITS-1:0][3:0]   digit_q, digit_d;
  logic [DIGITS-1:0]        blank_w;
  logic                     req_w;

  assign req_w = bus.score_clear | bus.add_valid;
  assign sum_w = {1'b0, score_q} + (SCORE_W + 1)'(bus.add_points);

  always_comb begin
    score_d = score_q;
    if (bus.score_clear) begin
      score_d = '0;
    end else if (bus.add_valid) begin
      score_d = (sum_w > SAT) ? SAT[SCORE_W-1:0] : sum_w[SCORE_W-1:0];
    end
  end

  // Double-dabble correction applied to the BCD field before each shift.
  always_comb begin
    adj_w = shift_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (shift_q[SCORE_W + 4*i +: 4] >= 4'd5) begin
        adj_w[SCORE_W + 4*i +: 4] = shift_q[SCORE_W + 4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    digit_d   = digit_q;
    pending_d = pending_q;
    case (state_q)
      S_IDLE: begin
        if (pending_q) begin
          shift_d   = {{BCD_W{1'b0}}, score_q};
          cnt_d     = '0;
          pending_d = 1'b0;
          state_d   = S_CONVERT;
        end
      end
      S_CONVERT: begin
        shift_d = adj_w << 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(SCORE_W - 1)) begin
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        for (int i = 0; i < DIGITS; i++) begin
          digit_d[i] = shift_q[SCORE_W + 4*i +: 4];
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A request in the same cycle as the IDLE load must survive it.
    if (req_w) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      score_q   <= '0;
      pending_q <= 1'b0;
      shift_q   <= '0;
      cnt_q     <= '0;
      digit_q   <= '0;
    end else begin
      state_q   <= state_d;
      score_q   <= score_d;
      pending_q <= pending_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      digit_q   <= digit_d;
    end
  end

`ifdef SCORE_BLANK_LZ_EN
  logic [DIGITS-1:0] blank_q, blank_d;

  // Blank flags run from the most significant digit down; digit 0 always renders.
  always_comb begin
    logic seen;
    seen    = 1'b0;
    blank_d = blank_q;
    if (state_q == S_COMMIT) begin
      for (int i = DIGITS - 1; i >= 1; i--) begin
        seen       = seen | (shift_q[SCORE_W + 4*i +: 4] != 4'd0);
        blank_d[i] = ~seen;
      end
      blank_d[0] = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      blank_q <= {{(DIGITS-1){1'b1}}, 1'b0};
    end else begin
      blank_q <= blank_d;
    end
  end

  assign blank_w = blank_q;
`else
  assign blank_w = '0;
`endif

  logic       in_box_w;
  logic [9:0] dx_w;
  logic [6:0] char_w;
  logic [2:0] col_w;
  logic [3:0] row_w;
  logic [4:0] glyph_w;
  logic [9:0] addr_d;
  logic [9:0] rom_addr_q;
  logic [2:0] col_q;
  logic       in_box_q;
  logic       pix_q;

  // Compare before subtracting so positions left of or above the box never alias.
  assign in_box_w = (bus.DrawX >= X0) && ({1'b0, bus.DrawX} < X_END) &&
                    (bus.DrawY >= Y0) && ({1'b0, bus.DrawY} < Y_END);
  assign dx_w     = bus.DrawX - X0;
  assign char_w   = dx_w[9:3];
  assign col_w    = dx_w[2:0];
  assign row_w    = bus.DrawY[3:0] - Y0[3:0];

  always_comb begin
    glyph_w = G_SPACE;
    if (char_w < 7'd7) begin
      glyph_w = char_w[4:0];
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        if (char_w == 7'(7 + DIGITS - 1 - i)) begin
          glyph_w = blank_w[i] ? G_SPACE : (5'(digit_q[i]) + 5'd7);
        end
      end
    end
    addr_d = in_box_w ? {1'b0, glyph_w, row_w} : {1'b0, G_SPACE, 4'd0};
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rom_addr_q <= '0;
      col_q      <= '0;
      in_box_q   <= 1'b0;
      pix_q      <= 1'b0;
    end else begin
      rom_addr_q <= addr_d;
      col_q      <= col_w;
      in_box_q   <= in_box_w;
      pix_q      <= in_box_q & bus.rom_data[3'd7 - col_q];
    end
  end

  assign bus.rom_addr    = rom_addr_q;
  assign bus.score_pixel = pix_q;
  assign bus.busy        = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_score_text_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_score_text_ctrl                                                   |
// | Scoreboard bench for score_text_ctrl (default build, leading zeros). |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_score_text_ctrl;
  localparam int X0 = 8;
  localparam int Y0 = 8;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  score_text_ctrl_if bus();
  score_text_ctrl dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  // Glyph ROM stand-in: row data equals the low address byte.
  assign bus.rom_data = bus.rom_addr[7:0];

  int checks = 0;
  int errors = 0;
  int score  = 0;
  int disp   = 0;

  logic [9:0] exp_addr_q[$];
  logic       exp_pix_q[$];
  logic probe_v = 1'b0, v1 = 1'b0, v2 = 1'b0;

  always @(posedge Clk) begin
    v1 <= probe_v;
    v2 <= v1;
  end

  // Monitor: rom_addr one edge after a probe, score_pixel one edge later.
  always @(negedge Clk) begin
    logic [9:0] ea;
    logic       ep;
    if (v1) begin
      checks++;
      if (exp_addr_q.size() == 0) begin
        errors++;
        $display("FAIL rom_addr_underflow got %0d want queued value", bus.rom_addr);
      end else begin
        ea = exp_addr_q.pop_front();
        if (bus.rom_addr !== ea) begin
          errors++;
          $display("FAIL rom_addr got %0d want %0d", bus.rom_addr, ea);
        end
      end
    end
    if (v2) begin
      checks++;
      if (exp_pix_q.size() == 0) begin
        errors++;
        $display("FAIL score_pixel_underflow got %0b want queued value", bus.score_pixel);
      end else begin
        ep = exp_pix_q.pop_front();
        if (bus.score_pixel !== ep) begin
          errors++;
          $display("FAIL score_pixel got %0b want %0b", bus.score_pixel, ep);
        end
      end
    end
  end

  function automatic void model(input int x, input int y, input int d,
                                output logic [9:0] a, output logic p);
    int c, col, row, g, pw;
    logic [7:0] b;
    if (x >= X0 && x < X0 + 96 && y >= Y0 && y < Y0 + 16) begin
      c   = (x - X0) / 8;
      col = (x - X0) % 8;
      row = y - Y0;
      if (c < 7) begin
        g = c;
      end else begin
        pw = 1;
        for (int k = 0; k < 11 - c; k++) pw = pw * 10;
        g = 7 + (d / pw) % 10;
      end
      a = 10'(g * 16 + row);
      b = a[7:0];
      p = b[7 - col];
    end else begin
      a = 10'd96;
      p = 1'b0;
    end
  endfunction

  task automatic probe(input int x, input int y);
    logic [9:0] a;
    logic       p;
    model(x, y, disp, a, p);
    exp_addr_q.push_back(a);
    exp_pix_q.push_back(p);
    bus.DrawX = 10'(x);
    bus.DrawY = 10'(y);
    probe_v   = 1'b1;
    @(negedge Clk);
    probe_v   = 1'b0;
  endtask

  task automatic drain();
    repeat (3) @(negedge Clk);
  endtask

  task automatic scan();
    int cols[3];
    cols = '{0, 3, 7};
    for (int c = 0; c < 12; c++) begin
      for (int j = 0; j < 3; j++) begin
        probe(X0 + 8 * c + cols[j], Y0 + ((c * 5 + cols[j]) % 16));
      end
    end
    drain();
  endtask

  task automatic chk(input string name, input logic [9:0] got, input logic [9:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic add(input int p);
    bus.add_valid  = 1'b1;
    bus.add_points = 8'(p);
    score = (score + p > 99999) ? 99999 : score + p;
    @(negedge Clk);
    bus.add_valid  = 1'b0;
  endtask

  task automatic clear();
    bus.score_clear = 1'b1;
    score = 0;
    @(negedge Clk);
    bus.score_clear = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0, quiet = 0;
    while (quiet < 3 && n < 300) begin
      @(negedge Clk);
      n++;
      if (!bus.busy) quiet++;
      else quiet = 0;
    end
    checks++;
    if (quiet < 3) begin
      errors++;
      $display("FAIL idle_timeout got busy=%0b want 0 within 300 cycles", bus.busy);
    end
    disp = score;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset           = 1'b1;
    bus.add_valid   = 1'b0;
    bus.add_points  = 8'd0;
    bus.score_clear = 1'b0;
    bus.DrawX       = 10'd0;
    bus.DrawY       = 10'd0;
    repeat (3) @(negedge Clk);
    chk("reset_busy", 10'(bus.busy), 10'd0);
    chk("reset_rom_addr", bus.rom_addr, 10'd0);
    chk("reset_pixel", 10'(bus.score_pixel), 10'd0);
    Reset = 1'b0;

    // 1: reset display and outside-box probes
    scan();
    probe(0, 0);
    probe(X0 - 1, Y0);
    probe(X0, Y0 - 1);
    probe(X0 + 96, Y0);
    probe(X0 + 95, Y0 + 16);
    probe(X0 + 95, Y0 + 15);
    probe(1023, 1023);
    drain();

    // 2: add 25, busy timeline and commit latency
    add(25);
    chk("busy_t1", 10'(bus.busy), 10'd0);
    @(negedge Clk);
    chk("busy_t2", 10'(bus.busy), 10'd1);
    repeat (17) @(negedge Clk);
    chk("busy_t19", 10'(bus.busy), 10'd1);
    disp = 0;
    probe(X0 + 88, Y0 + 2);
    chk("busy_t20", 10'(bus.busy), 10'd0);
    disp = 25;
    probe(X0 + 88, Y0 + 2);
    drain();
    wait_idle();
    scan();

    // 3: climb to 99990, then saturate
    clear();
    for (int i = 0; i < 392; i++) add(255);
    add(30);
    wait_idle();
    scan();
    add(200);
    wait_idle();
    scan();
    add(255);
    wait_idle();
    scan();

    // 4: back-to-back and mid-conversion adds, then a zero add
    clear();
    add(7);
    add(7);
    repeat (4) @(negedge Clk);
    add(7);
    wait_idle();
    scan();
    add(0);
    @(negedge Clk);
    chk("busy_zero_add", 10'(bus.busy), 10'd1);
    wait_idle();
    scan();

    // 5: clear wins over add, then reset mid-conversion
    bus.score_clear = 1'b1;
    bus.add_valid   = 1'b1;
    bus.add_points  = 8'd50;
    score = 0;
    @(negedge Clk);
    bus.score_clear = 1'b0;
    bus.add_valid   = 1'b0;
    wait_idle();
    scan();
    add(25);
    repeat (5) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("busy_after_reset", 10'(bus.busy), 10'd0);
    score = 0;
    disp  = 0;
    scan();
    add(1);
    wait_idle();
    scan();

    // 6: most significant digit 8
    clear();
    for (int i = 0; i < 313; i++) add(255);
    add(185);
    wait_idle();
    probe(X0 + 59, Y0 + 5);
    drain();
    scan();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
